// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch unit.
// Optional fetch counter is enabled with FETCH_PERF_CNT_EN.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_C = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_C    = 32'h00000000;
  localparam logic [31:0] INSTR_BYTES    = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Combinational instruction-memory bus between fetch and memory.
// Fetch drives the address; memory answers in the same cycle.
interface mips_fetch_if;
  import mips_fetch_pkg::*;

  logic [31:0] instr_address;
  logic [31:0] instr_readdata;

  modport master (
    output instr_address,
    input  instr_readdata
  );

  modport slave (
    input  instr_address,
    output instr_readdata
  );

endinterface

// File: rtl/mips_pc_next.sv
// Next-PC select with misaligned-target and halt detection.
// A fresh redirect takes priority over a pending one.
module mips_pc_next
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_C
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        pending_valid,
  input  logic [31:0] pending_target,
  output logic [31:0] next_pc,
  output logic        misaligned,
  output logic        halt_hit
);

  logic use_target;

  always_comb begin
    next_pc    = pc + INSTR_BYTES;
    use_target = 1'b0;
    priority case (1'b1)
      redirect_valid: begin
        next_pc    = redirect_target;
        use_target = 1'b1;
      end
      pending_valid: begin
        next_pc    = pending_target;
        use_target = 1'b1;
      end
      default: ;
    endcase
  end

  // pc+4 from an aligned pc can never be misaligned
  assign misaligned = use_target && is_misaligned(next_pc);
  assign halt_hit   = next_pc == HALT_ADDR;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: PC, delay-slot redirect, stall, halt and fault.
// FETCH_PERF_CNT_EN adds a saturating fetched-instruction counter.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  mips_fetch_if.master       imem,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic               if_valid,
  output logic               active,
  output logic               addr_error,
  output logic [31:0]        fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_instr_d, if_pc_d;
  logic         if_valid_d, active_d, addr_error_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_t_q, pend_t_d;
  logic [31:0]  next_pc;
  logic         misaligned, halt_hit;
  logic         fetch_load;

  assign imem.instr_address = pc_q;

  mips_pc_next #(
    .HALT_ADDR (HALT_ADDR)
  ) u_pc_next (
    .pc              (pc_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pending_valid   (pend_v_q),
    .pending_target  (pend_t_q),
    .next_pc         (next_pc),
    .misaligned      (misaligned),
    .halt_hit        (halt_hit)
  );

  assign fetch_load = (state_q == RUN) && !stall && !misaligned;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_instr_d   = if_instr;
    if_pc_d      = if_pc;
    if_valid_d   = if_valid;
    active_d     = active;
    addr_error_d = addr_error;
    pend_v_d     = pend_v_q;
    pend_t_d     = pend_t_q;
    unique case (state_q)
      RUN: begin
        if (stall) begin
          if (redirect_valid) begin
            pend_v_d = 1'b1;
            pend_t_d = redirect_target;
          end
        end else begin
          pend_v_d = 1'b0;
          if (misaligned) begin
            addr_error_d = 1'b1;
            if_valid_d   = 1'b0;
            active_d     = 1'b0;
            state_d      = FAULT;
          end else begin
            if_instr_d = imem.instr_readdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = next_pc;
            if (halt_hit) state_d = DRAIN;
          end
        end
      end
      // delay slot already sits in IF/ID; stop fetching
      DRAIN: begin
        if (!stall) begin
          if_valid_d = 1'b0;
          active_d   = 1'b0;
          state_d    = HALTED;
        end
      end
      HALTED: ;
      FAULT:  ;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      if_instr   <= '0;
      if_pc      <= '0;
      if_valid   <= 1'b0;
      active     <= 1'b1;
      addr_error <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr   <= if_instr_d;
      if_pc      <= if_pc_d;
      if_valid   <= if_valid_d;
      active     <= active_d;
      addr_error <= addr_error_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (fetch_load && cnt_q != 32'hFFFFFFFF)
      cnt_q <= cnt_q + 32'd1;
  end

  assign fetch_count = cnt_q;
`else
  logic unused_load;
  assign unused_load = fetch_load;
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
// Memory returns address ^ 32'hFFFF0000 for every fetch.
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] if_instr, if_pc, fetch_count;
  logic        if_valid, active, addr_error;

  int n_cmp = 0;
  int n_bad = 0;

  mips_fetch_if imem ();
  assign imem.instr_readdata = imem.instr_address ^ 32'hFFFF0000;

  mips_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .active          (active),
    .addr_error      (addr_error),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_addr", imem.instr_address, 32'hBFC00000);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_err", {31'd0, addr_error}, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);
    step();
    chk("f0_ifpc", if_pc, 32'hBFC00000);
    chk("f0_instr", if_instr, 32'h403F0000);
    chk("f0_valid", {31'd0, if_valid}, 32'd1);
    chk("f0_addr", imem.instr_address, 32'hBFC00004);
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step(); step();
    chk("br_ifpc", if_pc, 32'hBFC00008);
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00100;
    step();
    redirect_valid = 1'b0;
    chk("ds_ifpc", if_pc, 32'hBFC0000C);
    chk("ds_instr", if_instr, 32'h403F000C);
    chk("tgt_addr", imem.instr_address, 32'hBFC00100);
    step();
    chk("tgt_ifpc", if_pc, 32'hBFC00100);
    chk("tgt_next", imem.instr_address, 32'hBFC00104);
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      redirect_valid = (c == 1);
      redirect_target = 32'hBFC00040;
      step();
      chk("stl_ifpc", if_pc, 32'hBFC00004);
      chk("stl_addr", imem.instr_address, 32'hBFC00008);
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    step();
    chk("uns_ifpc", if_pc, 32'hBFC00008);
    chk("pend_addr", imem.instr_address, 32'hBFC00040);
    step();
    chk("pend_ifpc", if_pc, 32'hBFC00040);
    chk("pend_next", imem.instr_address, 32'hBFC00044);
`ifdef FETCH_PERF_CNT_EN
    chk("stl_cnt", fetch_count, 32'd4);
`else
    chk("stl_cnt", fetch_count, 32'd0);
`endif
  endtask

  task automatic test_halt();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h00000000;
    step();
    redirect_valid = 1'b0;
    chk("h_ds_ifpc", if_pc, 32'hBFC00004);
    chk("h_ds_valid", {31'd0, if_valid}, 32'd1);
    chk("h_addr", imem.instr_address, 32'h0);
    chk("h_act0", {31'd0, active}, 32'd1);
    step();
    chk("h_active", {31'd0, active}, 32'd0);
    chk("h_valid", {31'd0, if_valid}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("h_stay_act", {31'd0, active}, 32'd0);
      chk("h_stay_addr", imem.instr_address, 32'h0);
    end
    chk("h_hold_ifpc", if_pc, 32'hBFC00004);
  endtask

  task automatic test_fault();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00006;
    step();
    redirect_valid = 1'b0;
    chk("f_err", {31'd0, addr_error}, 32'd1);
    chk("f_active", {31'd0, active}, 32'd0);
    chk("f_valid", {31'd0, if_valid}, 32'd0);
    chk("f_addr", imem.instr_address, 32'hBFC00004);
    step(); step();
    chk("f_hold_addr", imem.instr_address, 32'hBFC00004);
    chk("f_hold_err", {31'd0, addr_error}, 32'd1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00200;
    step();
    redirect_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("m_valid", {31'd0, if_valid}, 32'd0);
    chk("m_addr", imem.instr_address, 32'hBFC00000);
    chk("m_ifpc", if_pc, 32'd0);
    chk("m_cnt", fetch_count, 32'd0);
    step();
    reset_n = 1'b1;
    stall = 1'b0;
    step();
    chk("m_f0", if_pc, 32'hBFC00000);
    chk("m_a1", imem.instr_address, 32'hBFC00004);
    step();
    chk("m_nopend", imem.instr_address, 32'hBFC00008);
    step(); step(); step();
`ifdef FETCH_PERF_CNT_EN
    chk("m_cnt5", fetch_count, 32'd5);
`else
    chk("m_cnt5", fetch_count, 32'd0);
`endif
    chk("m_a5", imem.instr_address, 32'hBFC00014);
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_halt();
    test_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- CPU-side initiator of the combinational instruction-memory interface: drives `instr_address`, samples `instr_readdata` the same cycle, and registers the result into an IF/ID holding register for decode.
- Owns the PC, starting at reset vector 0xBFC00000.
- Implements MIPS branch-delay-slot redirect, stall hold, and halt on reaching address 0x00000000.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that terminates execution.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  decode/backend hold; freezes PC and IF/ID.
- redirect_valid  input  1  decode reports taken branch/jump for instruction in IF/ID.
- redirect_target  input  32  branch/jump target address.
- instr_address  output  32  fetch address, equals PC, combinational from PC.
- instr_readdata  input  32  instruction word returned combinationally for `instr_address`.
- if_instr  output  32  registered instruction for decode.
- if_pc  output  32  registered address of `if_instr`.
- if_valid  output  1  `if_instr` and `if_pc` hold a real fetched instruction.
- active  output  1  CPU running; low once halted or faulted.
- addr_error  output  1  sticky; misaligned redirect target seen.
- fetch_count  output  32  number of instructions fetched (see Optional Feature).

Behaviour:
- Reset (async assert, sync effect on release): pc=RESET_VECTOR, state=RUN, if_instr=0, if_pc=0, if_valid=0, active=1, addr_error=0, pending_valid=0, pending_target=0, fetch_count=0.
- States:
  - RUN: fetching.
  - DRAIN: HALT_ADDR reached; last delay-slot instruction still in IF/ID.
  - HALTED: idle.
  - FAULT: misaligned target.
- RUN, stall=0, per cycle:
  - if_instr<=instr_readdata, if_pc<=pc, if_valid<=1.
  - pc<=next_pc.
- next_pc:
  - `redirect_valid` set: redirect_target.
  - else `pending_valid` set: pending_target, and pending_valid<=0.
  - else pc+4, 32-bit wrap with no overflow detection.
- Delay slot:
  - redirect is asserted while the branch sits in IF/ID; pc already points at branch_pc+4.
  - That delay-slot word is fetched this cycle unconditionally, then pc takes the target.
  - Latency from redirect to target on `instr_address`: 1 cycle.
- RUN, stall=1:
  - pc, if_* and fetch_count hold.
  - A `redirect_valid` seen during stall is latched into pending_valid/pending_target; a later redirect overwrites it.
  - The pending redirect is applied as next_pc on the first unstalled cycle.
  - If a redirect is both pending and newly asserted on that cycle, the new one wins.
- Halt:
  - When next_pc==HALT_ADDR would be loaded, pc<=HALT_ADDR and state<=DRAIN.
  - In DRAIN, with stall=0:
    - No fetch is latched; if_valid<=0, active<=0, state<=HALTED.
    - `instr_address` shows HALT_ADDR.
  - HALTED: all registers hold, if_valid=0, active=0. Leaves only via reset.
- Fault:
  - redirect_target[1:0]!=0 on the cycle it would be applied: addr_error<=1, if_valid<=0, active<=0, state<=FAULT.
  - pc is not updated. Leaves only via reset.
- Simultaneous stall and halt/fault condition: stall wins, evaluation deferred.
- Reset mid-operation returns every output to reset values immediately; a latched pending redirect is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments by 1 on every cycle that loads IF/ID with if_valid<=1.
  - Saturates at 32'hFFFFFFFF.
  - Holds in HALTED/FAULT.
- Undefined: fetch_count tied to 0, no counter flops.

Decomposition:
- Shared package mips_fetch_pkg:
  - fetch_state_t enum {RUN, DRAIN, HALTED, FAULT}.
  - Constants RESET_VECTOR_C=32'hBFC00000, HALT_ADDR_C=0, INSTR_BYTES=4.
- One sub-module mips_pc_next: combinational next_pc mux plus misalignment and halt detect.
- PC, pending, IF/ID and state registers stay in the top.

Test Plan:
- Reset release, stall=0 → cycle0 instr_address=0xBFC00000; next cycle if_pc=0xBFC00000, if_valid=1, instr_address=0xBFC00004.
- Redirect to 0xBFC00100 while if_pc=0xBFC00008 → delay slot 0xBFC0000C fetched, following address 0xBFC00100.
- Stall 3 cycles with redirect_valid pulsed to 0xBFC00040 in cycle 2 → pc/if_* frozen; first unstalled cycle fetches current pc, next address 0xBFC00040.
- `jr r0` program (redirect_target=0) → delay-slot nop fetched, instr_address=0, one cycle later active=0, if_valid=0, stays halted 10 cycles.
- redirect_target=0xBFC00006 → addr_error=1, active=0, pc unchanged.
- reset_n low mid-run with pending redirect → outputs reset asynchronously; after release fetch restarts at 0xBFC00000, pending ignored. With FETCH_PERF_CNT_EN, fetch_count=0 after reset and counts 5 after 5 unstalled fetches.
